axi4lite_cmd_queue: RTL

//  Upstream command stage for the AXI4-Lite master. Captures write/read commands from slow pad

---
 rtl/axi4lite_cmd_queue_pkg.sv | 20 ++
 rtl/axi4lite_cmd_queue_if.sv | 26 ++
 rtl/axi4lite_cmd_queue_sync_fifo.sv | 48 ++++
 rtl/axi4lite_cmd_queue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/axi4lite_cmd_queue_pkg.sv
// Shared types for the AXI4-Lite command queue: command record, FSM states
// and default bus widths.
package axi4lite_cmd_queue_pkg;

  localparam int CQ_ADDR_W = 2;
  localparam int CQ_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [CQ_ADDR_W-1:0] addr;
    logic [CQ_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/axi4lite_cmd_queue_if.sv
// User-side handshake between the command queue and the AXI4-Lite master.
// The queue owns the master modport; the master engine owns the slave modport.
interface axi4lite_cmd_queue_if
  import axi4lite_cmd_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = CQ_ADDR_W,
  parameter int DATA_WIDTH = CQ_DATA_W
);
  logic                  start_write;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  start_read;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  m_done;
  logic [DATA_WIDTH-1:0] m_read_data;

  modport master (
    output start_write, write_addr, write_data, start_read, read_addr,
    input  m_done, m_read_data
  );

  modport slave (
    input  start_write, write_addr, write_data, start_read, read_addr,
    output m_done, m_read_data
  );
endinterface

// File: rtl/axi4lite_cmd_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full are dropped
// regardless of a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/axi4lite_cmd_queue.sv
// Pad-side command capture, FIFO buffering and one-at-a-time issue to the
// AXI4-Lite master, with a WAIT timeout so a hung transfer cannot stall the queue.
module axi4lite_cmd_queue
  import axi4lite_cmd_queue_pkg::*;
#(
  parameter int ADDR_WIDTH     = CQ_ADDR_W,
  parameter int DATA_WIDTH     = CQ_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_strobe,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  axi4lite_cmd_queue_if.master  bus,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic                  timeout_err
);
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  localparam int         ENTRY_W  = $bits(entry_t);
  localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic                  strobe_p0, strobe_p1, strobe_p2;
  entry_t                cmd_p0, cmd_p1, head;
  logic                  push, pop, fifo_empty, tmo_hit, hold_we;
  logic [CNT_W-1:0]      fifo_count;
  logic [7:0]            tmo_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  state_t                state, state_nxt;

  // Stage p0/p1: two-flop synchronizer; p2: edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_p0 <= 1'b0;
      strobe_p1 <= 1'b0;
      strobe_p2 <= 1'b0;
    end else begin
      strobe_p0 <= cmd_strobe;
      strobe_p1 <= strobe_p0;
      strobe_p2 <= strobe_p1;
    end
  end

  always_ff @(posedge clk) begin
    cmd_p0 <= entry_t'({cmd_we, cmd_addr, cmd_wdata});
    cmd_p1 <= cmd_p0;
  end

  assign push = strobe_p1 && !strobe_p2;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_p1),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.m_done) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold registers load on pop so addr/data are stable before the start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_we     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      tmo_cnt     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) begin
        hold_we <= head.we;
        if (head.we) begin
          wr_addr_q <= head.addr;
          wr_data_q <= head.wdata;
        end else begin
          rd_addr_q <= head.addr;
        end
      end
      if (state == ISSUE) begin
        tmo_cnt <= '0;
        if (!hold_we) rd_valid <= 1'b0;
      end
      if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
        if (bus.m_done && !hold_we) begin
          rd_data  <= bus.m_read_data;
          rd_valid <= 1'b1;
        end
      end
      if (tmo_hit)             timeout_err <= 1'b1;
      if (push && fifo_full)   overflow    <= 1'b1;
    end
  end

  assign bus.start_write = (state == ISSUE) && hold_we;
  assign bus.start_read  = (state == ISSUE) && !hold_we;
  assign bus.write_addr  = wr_addr_q;
  assign bus.write_data  = wr_data_q;
  assign bus.read_addr   = rd_addr_q;
  assign busy            = (state != IDLE) || (fifo_count != '0);
endmodule
